mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register outputs and the MEM_WB register inputs.
- Performs word loads and stores against an internal data memory with configurable read latency.
- Stalls upstream while a load is outstanding and flags illegal accesses.
- Outputs map 1:1 onto MEM_WB inputs: rd→in1, alu result→in2, mem data→in3, ctrl→in4.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of 2).
- MEM_LAT, 2, load latency in cycles from accept edge to result (≥1).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- in_rd  in  5  destination register
- in_alu  in  32  ALU result / byte address
- in_wdata  in  32  store data (rt)
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_wb_ctrl  in  2  bit1 RegWrite, bit0 MemtoReg
- stall  out  1  upstream must hold EX/MEM contents
- out_valid  out  1  outputs hold a completed instruction this cycle
- out_rd  out  5  to MEM_WB in1
- out_alu  out  32  to MEM_WB in2
- out_mdata  out  32  to MEM_WB in3, load data
- out_wb_ctrl  out  2  to MEM_WB in4, forced 2'b00 when out_valid=0
- out_err  out  1  one-cycle pulse with out_valid: illegal access

Behaviour:
- Reset (async, rst_n=0): state IDLE; latency counter 0; stall=0; out_valid=0; out_rd=0; out_alu=0; out_mdata=0; out_wb_ctrl=0; out_err=0. The memory array is not reset.
- Accept: posedge with in_valid=1 and stall=0.
- States:
  - IDLE: waiting for an instruction.
  - WAIT: load outstanding; counter decrements each cycle.
- stall = (state==WAIT). It is a combinational function of state only.
- Non-memory op (read=0, write=0): registered to outputs at the accept edge; out_valid=1 the next cycle; out_mdata=0.
- Store: array[index] ← in_wdata at the accept edge. Outputs are registered as for a non-memory op, so a store completes in 1 cycle.
- Load, MEM_LAT=1: out_mdata = array[index] registered at the accept edge; no stall.
- Load, MEM_LAT>1:
  - Accept edge: go to WAIT with counter=MEM_LAT-1; capture rd, alu and ctrl into holding regs; out_valid=0.
  - Each WAIT edge: counter--.
  - Edge where counter==1: outputs load with the held fields plus array data, out_valid=1, return to IDLE.
  - Total: out_valid rises MEM_LAT cycles after the accept edge; stall is high for MEM_LAT-1 cycles.
- No accept edge (in_valid=0 or stall=1): out_valid=0 and out_wb_ctrl=00 next cycle (bubble into MEM_WB). Other out_* hold their values.
- index = in_alu[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- Illegal access is either of:
  - (read or write) with in_alu[1:0]≠0, or
  - read and write both set.
- On an illegal access:
  - no array write, no WAIT;
  - completes in 1 cycle with out_err=1;
  - out_wb_ctrl bit1 (RegWrite) cleared, bit0 passed through;
  - out_mdata=0.
- Store followed immediately by a load to the same word: the load returns the newly stored data, because the write happens at the earlier edge.
- Reset during WAIT: the load is abandoned; IDLE, outputs zeroed; the memory retains all prior stores.
- in_* are ignored while stall=1. Upstream holds them stable; the held copy is used.

Decomposition:
- Package mips_mem_pkg:
  - WB_REGWRITE=1, WB_MEMTOREG=0 (bit indices of the wb ctrl field);
  - mem_state_t {IDLE, WAIT};
  - WORD_W=32, REG_AW=5.
- Sub-module dmem_array: a DEPTH×32 synchronous-write array with a combinational read port. It holds no reset and no latency logic. mem_access_stage owns the FSM, latency counter and output registers.

Test Plan:
- Reset → stall=0, out_valid=0, all outputs 0. Deassert rst_n, then idle 3 cycles → out_valid stays 0, out_wb_ctrl=00.
- Store 0xDEADBEEF to addr 0x10 (rd=0, ctrl=00), then load addr 0x10 with rd=8, ctrl=11, MEM_LAT=2 → stall high exactly 1 cycle. out_valid pulse 2 cycles after load accept with out_rd=8, out_mdata=0xDEADBEEF, out_wb_ctrl=11.
- ALU op rd=3, alu=0x1234, ctrl=10 → next cycle out_valid=1, out_alu=0x1234, out_rd=3, out_mdata=0, no stall.
- Load addr 0x13 (misaligned), ctrl=11 → 1 cycle, out_err=1, out_wb_ctrl=01, no stall. Reading word 4 afterwards shows it unchanged. Repeat with read=write=1 → same result.
- Store 0xA5A5A5A5 to addr DEPTH*4+8 → a load from 0x8 returns 0xA5A5A5A5 (wrap).
- Start a load at MEM_LAT=4, assert rst_n=0 in the 2nd WAIT cycle → immediately stall=0, out_valid=0. After release, a load of the earlier-stored word still returns its data.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the MIPS MEM pipeline stage.
//   WORD_W / REG_AW      : datapath word width and register-address width
//   WB_REGWRITE/MEMTOREG : bit positions inside the 2-bit write-back control
//   mem_state_t          : MEM stage FSM states
//   is_illegal()         : classifies a memory access as illegal
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int WORD_W      = 32;
    localparam int REG_AW      = 5;
    localparam int WB_W        = 2;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // A memory access is illegal when it is misaligned, or when it asks for
    // both a read and a write in the same instruction.
    function automatic logic is_illegal(
        input logic       rd,
        input logic       wr,
        input logic [1:0] addr_lo
    );
        return ((rd | wr) && (addr_lo != 2'b00)) || (rd && wr);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit data memory. Synchronous write, combinational read.
// No reset: contents survive a pipeline reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_raddr  : read word index
//   o_rdata  : read data (combinational)
// ---------------------------------------------------------------------------
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Word write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of a 5-stage MIPS pipeline: word loads/stores to an internal
// data memory with MEM_LAT-cycle load latency, upstream stall while a load
// is outstanding, and illegal-access flagging.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_rd/in_alu      : EX/MEM instruction, dest reg, ALU result/addr
//   in_wdata                   : store data
//   in_mem_read/in_mem_write   : load / store request
//   in_wb_ctrl                 : {RegWrite, MemtoReg}
//   stall                      : upstream must hold EX/MEM contents
//   out_valid/out_rd/out_alu   : completed instruction to MEM_WB
//   out_mdata                  : load data (0 for non-loads)
//   out_wb_ctrl                : write-back control, 00 on bubbles
//   out_err                    : illegal access, pulses with out_valid
// ---------------------------------------------------------------------------
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [WORD_W-1:0] in_alu,
    input  logic [WORD_W-1:0] in_wdata,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [WB_W-1:0]   in_wb_ctrl,
    output logic              stall,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_rd,
    output logic [WORD_W-1:0] out_alu,
    output logic [WORD_W-1:0] out_mdata,
    output logic [WB_W-1:0]   out_wb_ctrl,
    output logic              out_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MEM_LAT + 1);

    mem_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [REG_AW-1:0] r_hold_rd;
    logic [WORD_W-1:0] r_hold_alu;
    logic [WB_W-1:0]   r_hold_ctrl;
    logic [AW-1:0]     r_hold_idx;

    logic              w_accept;
    logic              w_illegal;
    logic              w_we;
    logic [AW-1:0]     w_idx;
    logic [AW-1:0]     w_raddr;
    logic [WORD_W-1:0] w_rdata;

    assign stall     = (r_state == WAIT);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_idx     = in_alu[AW+1:2];
    assign w_illegal = is_illegal(in_mem_read, in_mem_write, in_alu[1:0]);
    assign w_we      = w_accept && in_mem_write && !w_illegal;
    // While a load is outstanding the held index drives the read port.
    assign w_raddr   = (r_state == WAIT) ? r_hold_idx : w_idx;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (in_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // FSM, latency counter, holding registers and MEM_WB-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= {CW{1'b0}};
            r_hold_rd   <= {REG_AW{1'b0}};
            r_hold_alu  <= {WORD_W{1'b0}};
            r_hold_ctrl <= {WB_W{1'b0}};
            r_hold_idx  <= {AW{1'b0}};
            out_valid   <= 1'b0;
            out_rd      <= {REG_AW{1'b0}};
            out_alu     <= {WORD_W{1'b0}};
            out_mdata   <= {WORD_W{1'b0}};
            out_wb_ctrl <= {WB_W{1'b0}};
            out_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_accept) begin
                        // Bubble into MEM_WB; data fields hold.
                        out_valid   <= 1'b0;
                        out_wb_ctrl <= {WB_W{1'b0}};
                        out_err     <= 1'b0;
                    end else if (w_illegal) begin
                        // Complete at once, never commit a register write.
                        out_valid   <= 1'b1;
                        out_rd      <= in_rd;
                        out_alu     <= in_alu;
                        out_mdata   <= {WORD_W{1'b0}};
                        out_wb_ctrl <= {1'b0, in_wb_ctrl[WB_MEMTOREG]};
                        out_err     <= 1'b1;
                    end else if (in_mem_read && (MEM_LAT > 1)) begin
                        r_state     <= WAIT;
                        r_cnt       <= CW'(MEM_LAT - 1);
                        r_hold_rd   <= in_rd;
                        r_hold_alu  <= in_alu;
                        r_hold_ctrl <= in_wb_ctrl;
                        r_hold_idx  <= w_idx;
                        out_valid   <= 1'b0;
                        out_wb_ctrl <= {WB_W{1'b0}};
                        out_err     <= 1'b0;
                    end else begin
                        // ALU op, store, or single-cycle load.
                        out_valid   <= 1'b1;
                        out_rd      <= in_rd;
                        out_alu     <= in_alu;
                        out_mdata   <= in_mem_read ? w_rdata : {WORD_W{1'b0}};
                        out_wb_ctrl <= in_wb_ctrl;
                        out_err     <= 1'b0;
                    end
                end
                WAIT: begin
                    out_err <= 1'b0;
                    if (r_cnt == CW'(1)) begin
                        r_state     <= IDLE;
                        r_cnt       <= {CW{1'b0}};
                        out_valid   <= 1'b1;
                        out_rd      <= r_hold_rd;
                        out_alu     <= r_hold_alu;
                        out_mdata   <= w_rdata;
                        out_wb_ctrl <= r_hold_ctrl;
                    end else begin
                        r_cnt       <= r_cnt - CW'(1);
                        out_valid   <= 1'b0;
                        out_wb_ctrl <= {WB_W{1'b0}};
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= {CW{1'b0}};
                    out_valid   <= 1'b0;
                    out_wb_ctrl <= {WB_W{1'b0}};
                    out_err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage. Two instances share the input bus:
// dut (MEM_LAT=2) carries the main checks, dut4 (MEM_LAT=4) is used for the
// reset-during-WAIT scenario.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        rst4_n;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [31:0] in_alu;
    logic [31:0] in_wdata;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_wb_ctrl;

    logic        stall,  out_valid,  out_err;
    logic [4:0]  out_rd;
    logic [31:0] out_alu, out_mdata;
    logic [1:0]  out_wb_ctrl;

    logic        stall4, out_valid4, out_err4;
    logic [4:0]  out_rd4;
    logic [31:0] out_alu4, out_mdata4;
    logic [1:0]  out_wb_ctrl4;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rd(in_rd),
        .in_alu(in_alu), .in_wdata(in_wdata), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_wb_ctrl(in_wb_ctrl),
        .stall(stall), .out_valid(out_valid), .out_rd(out_rd),
        .out_alu(out_alu), .out_mdata(out_mdata),
        .out_wb_ctrl(out_wb_ctrl), .out_err(out_err)
    );

    mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid), .in_rd(in_rd),
        .in_alu(in_alu), .in_wdata(in_wdata), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_wb_ctrl(in_wb_ctrl),
        .stall(stall4), .out_valid(out_valid4), .out_rd(out_rd4),
        .out_alu(out_alu4), .out_mdata(out_mdata4),
        .out_wb_ctrl(out_wb_ctrl4), .out_err(out_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic r, input logic w,
                         input logic [1:0] ctrl);
        in_valid     = v;
        in_rd        = rd;
        in_alu       = alu;
        in_wdata     = wd;
        in_mem_read  = r;
        in_mem_write = w;
        in_wb_ctrl   = ctrl;
    endtask

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        #3;
        chk("rst_stall",     {31'd0, stall},       32'd0);
        chk("rst_valid",     {31'd0, out_valid},   32'd0);
        chk("rst_rd",        {27'd0, out_rd},      32'd0);
        chk("rst_alu",       out_alu,              32'd0);
        chk("rst_mdata",     out_mdata,            32'd0);
        chk("rst_wb",        {30'd0, out_wb_ctrl}, 32'd0);
        chk("rst_err",       {31'd0, out_err},     32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        cycle(); cycle(); cycle();
        chk("idle_valid",    {31'd0, out_valid},   32'd0);
        chk("idle_wb",       {30'd0, out_wb_ctrl}, 32'd0);

        // Store DEADBEEF to 0x10, then load it back immediately.
        drive(1'b1, 5'd0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00);
        cycle();
        chk("st_valid",      {31'd0, out_valid},   32'd1);
        chk("st_stall",      {31'd0, stall},       32'd0);
        chk("st_mdata",      out_mdata,            32'd0);
        drive(1'b1, 5'd8, 32'h10, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("ld_stall1",     {31'd0, stall},       32'd1);
        chk("ld_valid_wait", {31'd0, out_valid},   32'd0);
        chk("ld_wb_wait",    {30'd0, out_wb_ctrl}, 32'd0);
        cycle();
        chk("ld_stall_end",  {31'd0, stall},       32'd0);
        chk("ld_valid",      {31'd0, out_valid},   32'd1);
        chk("ld_rd",         {27'd0, out_rd},      32'd8);
        chk("ld_alu",        out_alu,              32'h10);
        chk("ld_mdata",      out_mdata,            32'hDEADBEEF);
        chk("ld_wb",         {30'd0, out_wb_ctrl}, 32'd3);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        cycle();
        chk("bub_valid",     {31'd0, out_valid},   32'd0);
        chk("bub_wb",        {30'd0, out_wb_ctrl}, 32'd0);
        chk("bub_rd_hold",   {27'd0, out_rd},      32'd8);

        // Plain ALU op.
        drive(1'b1, 5'd3, 32'h1234, 32'h0, 1'b0, 1'b0, 2'b10);
        cycle();
        chk("alu_valid",     {31'd0, out_valid},   32'd1);
        chk("alu_alu",       out_alu,              32'h1234);
        chk("alu_rd",        {27'd0, out_rd},      32'd3);
        chk("alu_mdata",     out_mdata,            32'd0);
        chk("alu_wb",        {30'd0, out_wb_ctrl}, 32'd2);
        chk("alu_stall",     {31'd0, stall},       32'd0);

        // Misaligned load.
        drive(1'b1, 5'd5, 32'h13, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("mis_err",       {31'd0, out_err},     32'd1);
        chk("mis_valid",     {31'd0, out_valid},   32'd1);
        chk("mis_wb",        {30'd0, out_wb_ctrl}, 32'd1);
        chk("mis_stall",     {31'd0, stall},       32'd0);
        chk("mis_mdata",     out_mdata,            32'd0);

        // Read and write together at word 4.
        drive(1'b1, 5'd6, 32'h10, 32'h11111111, 1'b1, 1'b1, 2'b11);
        cycle();
        chk("rw_err",        {31'd0, out_err},     32'd1);
        chk("rw_wb",         {30'd0, out_wb_ctrl}, 32'd1);
        chk("rw_stall",      {31'd0, stall},       32'd0);
        chk("rw_mdata",      out_mdata,            32'd0);

        // Word 4 must still hold DEADBEEF.
        drive(1'b1, 5'd9, 32'h10, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("chk4_err_clr",  {31'd0, out_err},     32'd0);
        chk("chk4_stall",    {31'd0, stall},       32'd1);
        cycle();
        chk("chk4_valid",    {31'd0, out_valid},   32'd1);
        chk("chk4_mdata",    out_mdata,            32'hDEADBEEF);

        // Address wrap: DEPTH*4+8 aliases 0x8.
        drive(1'b1, 5'd0, DEPTH * 4 + 8, 32'hA5A5A5A5, 1'b0, 1'b1, 2'b00);
        cycle();
        chk("wrap_st_valid", {31'd0, out_valid},   32'd1);
        chk("wrap_st_err",   {31'd0, out_err},     32'd0);
        drive(1'b1, 5'd10, 32'h8, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("wrap_stall",    {31'd0, stall},       32'd1);
        cycle();
        chk("wrap_mdata",    out_mdata,            32'hA5A5A5A5);
        chk("wrap_rd",       {27'd0, out_rd},      32'd10);

        // Reset during WAIT on the MEM_LAT=4 instance.
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        cycle(); cycle(); cycle(); cycle();
        chk("l4_idle_stall", {31'd0, stall4},      32'd0);
        drive(1'b1, 5'd7, 32'h10, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("l4_wait1",      {31'd0, stall4},      32'd1);
        cycle();
        chk("l4_wait2",      {31'd0, stall4},      32'd1);
        rst4_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("l4_rst_stall",  {31'd0, stall4},      32'd0);
        chk("l4_rst_valid",  {31'd0, out_valid4},  32'd0);
        chk("l4_rst_rd",     {27'd0, out_rd4},     32'd0);
        chk("l4_rst_mdata",  out_mdata4,           32'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        cycle();
        drive(1'b1, 5'd7, 32'h10, 32'h0, 1'b1, 1'b0, 2'b11);
        cycle();
        chk("l4_s1",         {31'd0, stall4},      32'd1);
        cycle();
        chk("l4_s2",         {31'd0, stall4},      32'd1);
        cycle();
        chk("l4_s3",         {31'd0, stall4},      32'd1);
        chk("l4_s3_valid",   {31'd0, out_valid4},  32'd0);
        cycle();
        chk("l4_done_stall", {31'd0, stall4},      32'd0);
        chk("l4_valid",      {31'd0, out_valid4},  32'd1);
        chk("l4_rd",         {27'd0, out_rd4},     32'd7);
        chk("l4_mdata",      out_mdata4,           32'hDEADBEEF);
        chk("l4_wb",         {30'd0, out_wb_ctrl4},32'd3);
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00);
        cycle();
        chk("l4_bubble",     {31'd0, out_valid4},  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
